// File: rtl/axi4lite_xact_engine.sv
// AXI4-Lite transaction engine: command-driven master FSM plus register-file slave on an internal bus.
// Optional feature macro: AXI4LITE_RESP_ERR_EN (SLVERR for out-of-range register indices).
module axi4lite_xact_engine #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 6,
  localparam int STRB_W    = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_write,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_W-1:0]     wr_strb,
  input  logic                  start_read,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [1:0]            resp,
  output logic                  done,
  output logic                  busy
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   wr_addr_reg, rd_addr_reg;
  logic [DATA_WIDTH-1:0]   wr_data_reg, rd_data_reg;
  logic [STRB_W-1:0]       wr_strb_reg;
  logic [1:0]              resp_reg;
  logic                    rd_pend_reg, aw_sent_reg, w_sent_reg;

  // internal AXI4-Lite bus
  logic                    awvalid, awready, wvalid, wready, bvalid, bready;
  logic                    arvalid, arready, rvalid, rready;
  logic [ADDR_WIDTH-1:0]   awaddr, araddr;
  logic [DATA_WIDTH-1:0]   wdata, rdata;
  logic [STRB_W-1:0]       wstrb;
  logic [1:0]              bresp, rresp;
  logic                    aw_fire, w_fire, ar_fire;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < (ADDR_WIDTH+1)'(NUM_REGS);
  endfunction

  // ---------------- master ----------------
  assign awvalid = (state_reg == WR_REQ) && !aw_sent_reg;
  assign wvalid  = (state_reg == WR_REQ) && !w_sent_reg;
  assign bready  = (state_reg == WR_RESP);
  assign arvalid = (state_reg == RD_REQ);
  assign rready  = (state_reg == RD_DATA);
  assign awaddr  = wr_addr_reg;
  assign wdata   = wr_data_reg;
  assign wstrb   = wr_strb_reg;
  assign araddr  = rd_addr_reg;
  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign ar_fire = arvalid && arready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_write) state_next = WR_REQ;
               else if (start_read) state_next = RD_REQ;
      WR_REQ:  if ((aw_sent_reg || aw_fire) && (w_sent_reg || w_fire)) state_next = WR_RESP;
      WR_RESP: if (bvalid) state_next = DONE;
      RD_REQ:  if (ar_fire) state_next = RD_DATA;
      RD_DATA: if (rvalid) state_next = DONE;
      DONE:    state_next = rd_pend_reg ? RD_REQ : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      wr_strb_reg <= '0;
      rd_addr_reg <= '0;
      rd_pend_reg <= 1'b0;
      aw_sent_reg <= 1'b0;
      w_sent_reg  <= 1'b0;
      rd_data_reg <= '0;
      resp_reg    <= RESP_OKAY;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start_write) begin
            wr_addr_reg <= wr_addr;
            wr_data_reg <= wr_data;
            wr_strb_reg <= wr_strb;
          end
          if (start_read) rd_addr_reg <= rd_addr;
          // a simultaneous read is queued behind the write
          rd_pend_reg <= start_write && start_read;
        end
        WR_REQ: begin
          if (aw_fire) aw_sent_reg <= 1'b1;
          if (w_fire)  w_sent_reg  <= 1'b1;
          if (state_next != WR_REQ) begin
            aw_sent_reg <= 1'b0;
            w_sent_reg  <= 1'b0;
          end
        end
        WR_RESP: if (bvalid) resp_reg <= bresp;
        RD_DATA: if (rvalid) begin
          rd_data_reg <= rdata;
          resp_reg    <= rresp;
        end
        DONE:    rd_pend_reg <= 1'b0;
        default: ;
      endcase
    end
  end

  assign rd_data = rd_data_reg;
  assign resp    = resp_reg;
  assign done    = (state_reg == DONE);
  assign busy    = (state_reg != IDLE);

  // ---------------- slave ----------------
  logic [DATA_WIDTH-1:0] mem_reg [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd_view [2**ADDR_WIDTH];
  logic                  aw_full_reg, w_full_reg, bvalid_reg, rvalid_reg;
  logic [ADDR_WIDTH-1:0] aw_addr_hold_reg;
  logic [DATA_WIDTH-1:0] w_data_hold_reg, rdata_reg;
  logic [STRB_W-1:0]     w_strb_hold_reg;
  logic [1:0]            bresp_reg, rresp_reg;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] wa_eff;
  logic [DATA_WIDTH-1:0] wd_eff;
  logic [STRB_W-1:0]     ws_eff;

  // AW and W are captured independently; the write commits once both are present
  assign awready = awvalid && !aw_full_reg && !bvalid_reg;
  assign wready  = wvalid && !w_full_reg && !bvalid_reg;
  assign arready = arvalid && !rvalid_reg;
  assign commit  = (aw_full_reg || aw_fire) && (w_full_reg || w_fire);
  assign wa_eff  = aw_full_reg ? aw_addr_hold_reg : awaddr;
  assign wd_eff  = w_full_reg ? w_data_hold_reg : wdata;
  assign ws_eff  = w_full_reg ? w_strb_hold_reg : wstrb;
  assign bvalid  = bvalid_reg;
  assign bresp   = bresp_reg;
  assign rvalid  = rvalid_reg;
  assign rdata   = rdata_reg;
  assign rresp   = rresp_reg;

  generate
    for (genvar gi = 0; gi < 2**ADDR_WIDTH; gi++) begin : g_view
      if (gi < NUM_REGS) begin : g_impl
        assign rd_view[gi] = mem_reg[gi];
      end else begin : g_pad
        assign rd_view[gi] = '0;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) mem_reg[r] <= '0;
    end else if (commit && in_range(wa_eff)) begin
      for (int r = 0; r < NUM_REGS; r++)
        for (int b = 0; b < STRB_W; b++)
          if (wa_eff == ADDR_WIDTH'(r) && ws_eff[b]) mem_reg[r][b*8 +: 8] <= wd_eff[b*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full_reg      <= 1'b0;
      w_full_reg       <= 1'b0;
      aw_addr_hold_reg <= '0;
      w_data_hold_reg  <= '0;
      w_strb_hold_reg  <= '0;
      bvalid_reg       <= 1'b0;
      bresp_reg        <= RESP_OKAY;
      rvalid_reg       <= 1'b0;
      rdata_reg        <= '0;
      rresp_reg        <= RESP_OKAY;
    end else begin
      if (commit) begin
        aw_full_reg <= 1'b0;
        w_full_reg  <= 1'b0;
        bvalid_reg  <= 1'b1;
`ifdef AXI4LITE_RESP_ERR_EN
        bresp_reg   <= in_range(wa_eff) ? RESP_OKAY : RESP_SLVERR;
`else
        bresp_reg   <= RESP_OKAY;
`endif
      end else begin
        if (aw_fire) begin
          aw_full_reg      <= 1'b1;
          aw_addr_hold_reg <= awaddr;
        end
        if (w_fire) begin
          w_full_reg      <= 1'b1;
          w_data_hold_reg <= wdata;
          w_strb_hold_reg <= wstrb;
        end
        if (bvalid_reg && bready) bvalid_reg <= 1'b0;
      end
      if (ar_fire) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rd_view[araddr];
`ifdef AXI4LITE_RESP_ERR_EN
        rresp_reg  <= in_range(araddr) ? RESP_OKAY : RESP_SLVERR;
`else
        rresp_reg  <= RESP_OKAY;
`endif
      end else if (rvalid_reg && rready) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi4lite_xact_engine.sv
// Scoreboard bench for axi4lite_xact_engine: stimulus pushes expected completions, a monitor pops on done.
module tb_axi4lite_xact_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_write = 1'b0, start_read = 1'b0;
  logic [2:0]  wr_addr = '0, rd_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_strb = '0;
  logic [15:0] rd_data;
  logic [1:0]  resp;
  logic        done, busy;

`ifdef AXI4LITE_RESP_ERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  typedef struct {
    bit          is_rd;
    logic [15:0] data;
    logic [1:0]  resp;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, failures = 0, cyc = 0, proto_err = 0;
  logic pv_aw = 0, pv_w = 0, pv_ar = 0, pv_b = 0, pv_r = 0;

  axi4lite_xact_engine #(.ADDR_WIDTH(3), .DATA_WIDTH(16), .NUM_REGS(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_write(start_write), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .start_read(start_read), .rd_addr(rd_addr),
    .rd_data(rd_data), .resp(resp), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Called at a negedge with the DUT idle; done is expected 3 cycles later (6 for a queued read).
  task automatic issue(input bit w, input logic [2:0] wa, input logic [15:0] wd, input logic [1:0] ws,
                       input logic [1:0] wresp, input bit r, input logic [2:0] ra,
                       input logic [15:0] rexp, input logic [1:0] rresp);
    exp_t e;
    start_write = w; wr_addr = wa; wr_data = wd; wr_strb = ws;
    start_read  = r; rd_addr = ra;
    if (w) begin
      e.is_rd = 0; e.data = '0; e.resp = wresp; e.cyc = cyc + 3;
      exp_q.push_back(e);
    end
    if (r) begin
      e.is_rd = 1; e.data = rexp; e.resp = rresp; e.cyc = cyc + (w ? 6 : 3);
      exp_q.push_back(e);
    end
    @(negedge clk);
    start_write = 0; start_read = 0;
    check("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  // Monitor: protocol watch plus scoreboard pop on every done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if ($isunknown({dut.awvalid, dut.wvalid, dut.arvalid, dut.bvalid, dut.rvalid,
                      dut.awready, dut.wready, dut.arready, dut.bready, dut.rready}))
        proto_err++;
      if ((pv_aw && !dut.awvalid) || (pv_w && !dut.wvalid) || (pv_ar && !dut.arvalid) ||
          (pv_b && !dut.bvalid) || (pv_r && !dut.rvalid))
        proto_err++;
      pv_aw = dut.awvalid && !dut.awready;
      pv_w  = dut.wvalid  && !dut.wready;
      pv_ar = dut.arvalid && !dut.arready;
      pv_b  = dut.bvalid  && !dut.bready;
      pv_r  = dut.rvalid  && !dut.rready;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("xact %s cyc=%0d resp=%b rd_data=%h (exp cyc=%0d resp=%b data=%h)",
                   e.is_rd ? "RD" : "WR", cyc, resp, rd_data, e.cyc, e.resp, e.data);
          check("done_cycle", cyc, e.cyc);
          check("resp", {30'b0, resp}, {30'b0, e.resp});
          if (e.is_rd) check("rd_data", {16'b0, rd_data}, {16'b0, e.data});
        end
      end
    end else begin
      pv_aw = 0; pv_w = 0; pv_ar = 0; pv_b = 0; pv_r = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_rd_data", {16'b0, rd_data}, 32'd0);
    check("reset_resp", {30'b0, resp}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // full write then read back
    issue(1, 3'd2, 16'hA5C3, 2'b11, 2'b00, 0, 3'd0, 16'h0000, 2'b00); drain();
    issue(0, 3'd0, 16'h0000, 2'b00, 2'b00, 1, 3'd2, 16'hA5C3, 2'b00); drain();
    // low-byte-only write
    issue(1, 3'd2, 16'h1234, 2'b01, 2'b00, 0, 3'd0, 16'h0000, 2'b00); drain();
    issue(0, 3'd0, 16'h0000, 2'b00, 2'b00, 1, 3'd2, 16'hA534, 2'b00); drain();
    // simultaneous write+read: read queued, sees the new data
    issue(1, 3'd4, 16'h00FF, 2'b11, 2'b00, 1, 3'd4, 16'h00FF, 2'b00); drain();
    // out-of-range index 7
    issue(1, 3'd7, 16'hFFFF, 2'b11, OOR_RESP, 0, 3'd0, 16'h0000, 2'b00); drain();
    issue(0, 3'd0, 16'h0000, 2'b00, 2'b00, 1, 3'd7, 16'h0000, OOR_RESP); drain();
    // last implemented register and first unimplemented one
    issue(1, 3'd5, 16'h5A5A, 2'b11, 2'b00, 0, 3'd0, 16'h0000, 2'b00); drain();
    issue(0, 3'd0, 16'h0000, 2'b00, 2'b00, 1, 3'd5, 16'h5A5A, 2'b00); drain();
    issue(1, 3'd6, 16'hBEEF, 2'b11, OOR_RESP, 0, 3'd0, 16'h0000, 2'b00); drain();
    issue(0, 3'd0, 16'h0000, 2'b00, 2'b00, 1, 3'd6, 16'h0000, OOR_RESP); drain();
    // zero strobe: handshake completes, nothing changes
    issue(1, 3'd2, 16'hFFFF, 2'b00, 2'b00, 0, 3'd0, 16'h0000, 2'b00); drain();
    issue(0, 3'd0, 16'h0000, 2'b00, 2'b00, 1, 3'd2, 16'hA534, 2'b00); drain();

    // starts while busy are ignored
    issue(0, 3'd0, 16'h0000, 2'b00, 2'b00, 1, 3'd4, 16'h00FF, 2'b00);
    for (int i = 0; i < 2; i++) begin
      start_read = 1; rd_addr = 3'd5; start_write = 1; wr_addr = 3'd2; wr_data = 16'h0000; wr_strb = 2'b11;
      @(negedge clk);
    end
    start_read = 0; start_write = 0;
    drain();
    repeat (8) @(negedge clk);
    issue(0, 3'd0, 16'h0000, 2'b00, 2'b00, 1, 3'd2, 16'hA534, 2'b00); drain();

    // reset during cycle 1 of a write to register 1
    start_write = 1; wr_addr = 3'd1; wr_data = 16'hBEEF; wr_strb = 2'b11;
    @(negedge clk);
    start_write = 0;
    rst_n = 1'b0;
    #1;
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_rd_data", {16'b0, rd_data}, 32'd0);
    repeat (2) @(negedge clk);
    check("abort_done_held", {31'b0, done}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    issue(0, 3'd0, 16'h0000, 2'b00, 2'b00, 1, 3'd1, 16'h0000, 2'b00); drain();
    issue(0, 3'd0, 16'h0000, 2'b00, 2'b00, 1, 3'd2, 16'h0000, 2'b00); drain();

    check("protocol_clean", proto_err, 0);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
